insn_encoder: RTL and testbench

- Inverse of the immediate extender: packs an immediate plus register/opcode fields into a 32-bit RV32I instruction word.
- Used by the self-test instruction generator and the trap-stub writer that build instructions at run time.
- Valid/ready input, range check on the immediate, 2-entry output buffer with valid/ready backpressure.
- Round trip: feeding out_insn and the same fmt code to the extender returns the original legal immediate.

---
 rtl/insn_encoder.sv | 140 ++++++++++++++
 tb/tb_insn_encoder.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_encoder.sv
// RV32I instruction packer: immediate plus register/opcode fields -> 32-bit word, behind a 2-entry FIFO.
// Optional saturating error counter port err_count is enabled by defining INSN_ENCODER_ERR_CNT_EN.
module insn_encoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic        out_err
`ifdef INSN_ENCODER_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_U = 3'b001;
    localparam logic [2:0] FMT_J = 3'b010;
    localparam logic [2:0] FMT_B = 3'b011;
    localparam logic [2:0] FMT_S = 3'b100;

    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef struct packed {
        logic        err;
        logic [31:0] insn;
    } entry_t;

    // Immediate fits the signed field when every bit above the field's sign bit copies it.
    logic fits_12;
    logic fits_13;
    logic fits_21;

    assign fits_12 = (imm[31:11] == {21{imm[11]}});
    assign fits_13 = (imm[31:12] == {20{imm[12]}});
    assign fits_21 = (imm[31:20] == {12{imm[20]}});

    entry_t packed_entry;

    // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
    always_comb begin
        packed_entry.insn = {funct7, rs2, rs1, funct3, rd, opcode};
        packed_entry.err  = 1'b0;
        case (fmt)
            FMT_I: begin
                packed_entry.insn = {imm[11:0], rs1, funct3, rd, opcode};
                packed_entry.err  = !fits_12;
            end
            FMT_U: begin
                packed_entry.insn = {imm[31:12], rd, opcode};
                packed_entry.err  = |imm[11:0];
            end
            FMT_J: begin
                packed_entry.insn = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                packed_entry.err  = !fits_21 || imm[0];
            end
            FMT_B: begin
                packed_entry.insn = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                packed_entry.err  = !fits_13 || imm[0];
            end
            FMT_S: begin
                packed_entry.insn = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                packed_entry.err  = !fits_12;
            end
            default: begin
                packed_entry.insn = {funct7, rs2, rs1, funct3, rd, opcode};
                packed_entry.err  = 1'b0;
            end
        endcase
    end

    entry_t     mem [DEPTH];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    entry_t     head;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is not reset; count gates the outputs, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= packed_entry;
        end
    end

    assign head     = mem[rd_ptr];
    assign out_insn = out_valid ? head.insn : 32'd0;
    assign out_err  = out_valid ? head.err  : 1'b0;

`ifdef INSN_ENCODER_ERR_CNT_EN
    // Counted when the request is accepted, independent of when the consumer drains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 16'd0;
        end else if (push && packed_entry.err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: directed scenarios plus a scoreboard monitor on the output stream.
module tb_insn_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic        out_err;
`ifdef INSN_ENCODER_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic [32:0] exp_q[$];

    insn_encoder #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .imm       (imm),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_insn  (out_insn),
        .out_err   (out_err)
`ifdef INSN_ENCODER_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference encoder; legality is judged by signed range rather than by bit patterns.
    function automatic logic [32:0] model(input logic [2:0] f, input logic [31:0] i,
                                          input logic [6:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [2:0] f3, input logic [6:0] f7);
        logic [31:0] w;
        logic        e;
        int          v;
        v = $signed(i);
        w = {f7, s2, s1, f3, d, op};
        e = 1'b0;
        case (f)
            3'd0: begin
                w = {i[11:0], s1, f3, d, op};
                e = (v < -2048) || (v > 2047);
            end
            3'd1: begin
                w = {i[31:12], d, op};
                e = (i[11:0] != 12'd0);
            end
            3'd2: begin
                w = {i[20], i[10:1], i[11], i[19:12], d, op};
                e = (v < -(1 << 20)) || (v >= (1 << 20)) || i[0];
            end
            3'd3: begin
                w = {i[12], i[10:5], s2, s1, f3, i[4:1], i[11], op};
                e = (v < -4096) || (v >= 4096) || i[0];
            end
            3'd4: begin
                w = {i[11:5], s2, s1, f3, i[4:0], op};
                e = (v < -2048) || (v > 2047);
            end
            default: begin
                w = {f7, s2, s1, f3, d, op};
                e = 1'b0;
            end
        endcase
        return {e, w};
    endfunction

    // Immediate extender, used to prove the round trip on emitted words.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f);
        logic [31:0] r;
        case (f)
            3'd0:    r = {{20{w[31]}}, w[31:20]};
            3'd1:    r = {w[31:12], 12'd0};
            3'd2:    r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            3'd3:    r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4:    r = {{20{w[31]}}, w[31:25], w[11:7]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Scoreboard: handshakes seen at the falling edge complete on the following rising edge.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n === 1'b1) begin
            n_vec++;
            if (out_valid !== (exp_q.size() != 0)) begin
                n_miss++;
                $display("FAIL sb_out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
            end
            n_vec++;
            if (in_ready !== (exp_q.size() < 2)) begin
                n_miss++;
                $display("FAIL sb_in_ready: got %b expected %b", in_ready, exp_q.size() < 2);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL sb_unexpected_pop: got %h expected nothing", {out_err, out_insn});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_err, out_insn} !== e) begin
                        n_miss++;
                        $display("FAIL sb_word: got err=%b insn=%h expected err=%b insn=%h",
                                 out_err, out_insn, e[32], e[31:0]);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                exp_q.push_back(model(fmt, imm, opcode, rd, rs1, rs2, funct3, funct7));
            end
        end
    end

    task automatic drive(input logic [2:0] f, input logic [31:0] i, input logic [6:0] op,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] f3, input logic [6:0] f7);
        fmt = f; imm = i; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
        in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_insn !== 32'd0 || out_err !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state: got v=%b r=%b insn=%h err=%b expected v=0 r=1 insn=0 err=0",
                     out_valid, in_ready, out_insn, out_err);
        end
`ifdef INSN_ENCODER_ERR_CNT_EN
        n_vec++;
        if (err_count !== 16'd0) begin
            n_miss++;
            $display("FAIL reset_err_count: got %0d expected 0", err_count);
        end
`endif
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(3'd0, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_insn !== 32'h00500093 || out_err !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_i: got v=%b insn=%h err=%b expected v=1 insn=00500093 err=0",
                     out_valid, out_insn, out_err);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL basic_drained: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'h00500093;
        words[1] = 32'h12345137;
        words[2] = 32'h008000EF;
        out_ready = 1'b1;
        drive(3'd0, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            case (k)
                0:       drive(3'd1, 32'h12345000, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0);
                1:       drive(3'd2, 32'd8, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
                default: in_valid = 1'b0;
            endcase
            n_vec++;
            if (out_valid !== 1'b1 || out_insn !== words[k] || out_err !== 1'b0) begin
                n_miss++;
                $display("FAIL b2b_word%0d: got v=%b insn=%h err=%b expected v=1 insn=%h err=0",
                         k, out_valid, out_insn, out_err, words[k]);
            end
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_drained: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_b_s();
        out_ready = 1'b1;
        drive(3'd3, 32'hFFFFFFFC, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0);
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_insn !== 32'hFE208EE3 || out_err !== 1'b0 || extend(out_insn, 3'd3) !== 32'hFFFFFFFC) begin
            n_miss++;
            $display("FAIL b_word: got insn=%h err=%b imm_back=%h expected insn=FE208EE3 err=0 imm_back=FFFFFFFC",
                     out_insn, out_err, extend(out_insn, 3'd3));
        end
        step();
        drive(3'd4, 32'd8, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0);
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_insn !== 32'h0020A423 || out_err !== 1'b0 || extend(out_insn, 3'd4) !== 32'd8) begin
            n_miss++;
            $display("FAIL s_word: got insn=%h err=%b imm_back=%h expected insn=0020A423 err=0 imm_back=00000008",
                     out_insn, out_err, extend(out_insn, 3'd4));
        end
        step();
    endtask

    task automatic test_errors();
        out_ready = 1'b1;
        drive(3'd0, 32'h00000800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_insn !== 32'h80000093 || out_err !== 1'b1) begin
            n_miss++;
            $display("FAIL err_i: got insn=%h err=%b expected insn=80000093 err=1", out_insn, out_err);
        end
        step();
        drive(3'd3, 32'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0);
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_err !== 1'b1) begin
            n_miss++;
            $display("FAIL err_b: got err=%b expected 1", out_err);
        end
        step();
        drive(3'd1, 32'h00001001, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0);
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_err !== 1'b1) begin
            n_miss++;
            $display("FAIL err_u: got err=%b expected 1", out_err);
        end
        step();
`ifdef INSN_ENCODER_ERR_CNT_EN
        n_vec++;
        if (err_count !== 16'd3) begin
            n_miss++;
            $display("FAIL err_count: got %0d expected 3", err_count);
        end
`endif
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(3'd0, 32'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0);
        step();
        n_vec++;
        if (in_ready !== 1'b1 || out_insn !== 32'h00100193) begin
            n_miss++;
            $display("FAIL bp_first: got r=%b insn=%h expected r=1 insn=00100193", in_ready, out_insn);
        end
        drive(3'd0, 32'd2, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0);
        step();
        n_vec++;
        if (in_ready !== 1'b0 || out_insn !== 32'h00100193) begin
            n_miss++;
            $display("FAIL bp_full: got r=%b insn=%h expected r=0 insn=00100193", in_ready, out_insn);
        end
        drive(3'd0, 32'd3, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_insn !== 32'h00100193 || out_err !== 1'b0) begin
                n_miss++;
                $display("FAIL bp_stall%0d: got r=%b v=%b insn=%h err=%b expected r=0 v=1 insn=00100193 err=0",
                         k, in_ready, out_valid, out_insn, out_err);
            end
        end
        out_ready = 1'b1;
        step();
        n_vec++;
        if (in_ready !== 1'b1 || out_insn !== 32'h00200213) begin
            n_miss++;
            $display("FAIL bp_pop1: got r=%b insn=%h expected r=1 insn=00200213", in_ready, out_insn);
        end
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_insn !== 32'h00300293) begin
            n_miss++;
            $display("FAIL bp_pop2: got v=%b insn=%h expected v=1 insn=00300293", out_valid, out_insn);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL bp_drained: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic acc;
        int   cyc;
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 2))
                0:       imm = $urandom;
                1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                default: imm = {$urandom_range(0, 1) != 0 ? 12'hFFF : 12'h000, 20'($urandom)};
            endcase
            drive(3'($urandom_range(0, 7)), imm, 7'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom));
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 20) begin
                @(negedge clk);
                acc = in_ready;
                step();
                out_ready = ($urandom_range(0, 3) != 0);
                cyc++;
            end
            if (!acc) begin
                n_vec++;
                n_miss++;
                $display("FAIL rand_accept_timeout: got no accept in %0d cycles expected accept", cyc);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL rand_drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(3'd0, 32'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0);
        step();
        drive(3'd0, 32'd2, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_insn !== 32'd0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL rst_async: got v=%b insn=%h err=%b r=%b expected v=0 insn=0 err=0 r=1",
                     out_valid, out_insn, out_err, in_ready);
        end
        step();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_hold: got r=%b v=%b expected r=1 v=0", in_ready, out_valid);
        end
`ifdef INSN_ENCODER_ERR_CNT_EN
        n_vec++;
        if (err_count !== 16'd0) begin
            n_miss++;
            $display("FAIL rst_err_count: got %0d expected 0", err_count);
        end
`endif
        #2;
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        drive(3'd0, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_insn !== 32'h00500093 || out_err !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_after: got v=%b insn=%h err=%b expected v=1 insn=00500093 err=0",
                     out_valid, out_insn, out_err);
        end
        step();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL rst_no_stale: got out_valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fmt = 3'd0; imm = 32'd0; opcode = 7'd0; rd = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_b_s();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
